// File: rtl/hdlc_pkg.sv
// Shared constants, receive FSM state type and the serial CRC step for the HDLC receive path.
package hdlc_pkg;

  localparam logic [7:0]  FLAG        = 8'h7E;
  localparam int          ABORT_ONES  = 7;
  // Eight-sample window (oldest bit in [0]) holding a 0 followed by ABORT_ONES 1s.
  localparam logic [7:0]  ABORT_PAT   = {{ABORT_ONES{1'b1}}, 1'b0};
  localparam logic [15:0] CRC_POLY    = 16'h1021;
  localparam logic [15:0] CRC_INIT    = 16'h0000;
  localparam logic [15:0] CRC_RESIDUE = 16'h0000;

  typedef enum logic {
    IDLE  = 1'b0,
    FRAME = 1'b1
  } rx_state_t;

  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic b);
    logic fb;
    fb = crc[15] ^ b;
    return {crc[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/hdlc_crc16.sv
// Bit-serial CRC-16 register with enable and synchronous clear.
module hdlc_crc16
  import hdlc_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        en_i,
  input  logic        clr_i,
  input  logic        bit_i,
  output logic [15:0] crc_o
);

  logic [15:0] crc_q;
  logic [15:0] crc_d;

  always_comb begin
    crc_d = crc_q;
    if (clr_i)
      crc_d = CRC_INIT;
    else if (en_i)
      crc_d = crc16_step(crc_q, bit_i);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni)
      crc_q <= CRC_INIT;
    else
      crc_q <= crc_d;
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/hdlc_rx_deframer.sv
// HDLC receive bit front end: flag/abort detection, zero removal, byte assembly.
// Optional FCS residue check and minimum-length check under HDLC_RX_FCS_CHECK_EN.
module hdlc_rx_deframer
  import hdlc_pkg::*;
(
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Rx,
  input  logic       RxEN,
  output logic [7:0] Rx_Data,
  output logic       Rx_NewByte,
  output logic       Rx_FlagDetect,
  output logic       Rx_AbortDetect,
  output logic       Rx_ValidFrame,
  output logic       Rx_EoF,
  output logic       Rx_FrameError,
  output logic       Rx_FCSerr
);

  logic run_n;
  assign run_n = Rst & RxEN;

  // Sample window: newest bit enters at [7], the bit leaving at [0] is the data candidate.
  logic [7:0] win_q;
  logic [3:0] fill_q;

  always_ff @(posedge Clk) begin
    if (!run_n) begin
      win_q  <= '0;
      fill_q <= '0;
    end else begin
      win_q <= {Rx, win_q[7:1]};
      if (fill_q != 4'd8)
        fill_q <= fill_q + 4'd1;
    end
  end

  logic flag_b_q, abort_b_q, bit_b_q;

  always_ff @(posedge Clk) begin
    if (!run_n) begin
      flag_b_q  <= 1'b0;
      abort_b_q <= 1'b0;
      bit_b_q   <= 1'b0;
    end else begin
      flag_b_q  <= (fill_q == 4'd8) && (win_q == FLAG);
      abort_b_q <= (fill_q == 4'd8) && (win_q == ABORT_PAT);
      bit_b_q   <= win_q[0];
    end
  end

  rx_state_t  state_q;
  logic [2:0] skip_q, ones_q, bitcnt_q;
  logic       had_data_q;
  logic [7:0] asm_q, data_q;
  logic       flag_q, abort_q, nb_q, valid_q, eof_q, ferr_q;
  logic [7:0] asm_d;
  logic       data_bit_d;
  logic       frame_bad_d;

  always_comb begin
    asm_d      = {bit_b_q, asm_q[7:1]};
    data_bit_d = 1'b0;
    if (!flag_b_q && !abort_b_q && state_q == FRAME && skip_q == 3'd0)
      data_bit_d = !(ones_q == 3'd5 && !bit_b_q);
  end

`ifdef HDLC_RX_FCS_CHECK_EN
  logic [15:0] crc;
  logic [1:0]  bytes_q;
  logic        fcserr_q;

  hdlc_crc16 u_crc (
    .clk_i  (Clk),
    .rst_ni (run_n),
    .en_i   (data_bit_d),
    .clr_i  (flag_b_q | abort_b_q),
    .bit_i  (bit_b_q),
    .crc_o  (crc)
  );

  assign frame_bad_d = (bitcnt_q != 3'd0) || (bytes_q != 2'd2);
  assign Rx_FCSerr   = fcserr_q;
`else
  assign frame_bad_d = (bitcnt_q != 3'd0);
  assign Rx_FCSerr   = 1'b0;
`endif

  always_ff @(posedge Clk) begin
    if (!run_n) begin
      state_q    <= IDLE;
      skip_q     <= '0;
      ones_q     <= '0;
      bitcnt_q   <= '0;
      had_data_q <= 1'b0;
      asm_q      <= '0;
      data_q     <= '0;
      flag_q     <= 1'b0;
      abort_q    <= 1'b0;
      nb_q       <= 1'b0;
      valid_q    <= 1'b0;
      eof_q      <= 1'b0;
      ferr_q     <= 1'b0;
`ifdef HDLC_RX_FCS_CHECK_EN
      bytes_q    <= '0;
      fcserr_q   <= 1'b0;
`endif
    end else begin
      flag_q  <= flag_b_q;
      abort_q <= abort_b_q;
      nb_q    <= 1'b0;
      eof_q   <= 1'b0;
      ferr_q  <= 1'b0;
      // Lags the state by one cycle so it stays high during the abort pulse.
      valid_q <= (state_q == FRAME);
`ifdef HDLC_RX_FCS_CHECK_EN
      fcserr_q <= 1'b0;
`endif
      if (flag_b_q) begin
        if (state_q == FRAME && had_data_q) begin
          eof_q  <= 1'b1;
          ferr_q <= frame_bad_d;
`ifdef HDLC_RX_FCS_CHECK_EN
          fcserr_q <= (crc != CRC_RESIDUE);
`endif
        end
        state_q    <= FRAME;
        skip_q     <= 3'd7;
        ones_q     <= '0;
        bitcnt_q   <= '0;
        had_data_q <= 1'b0;
`ifdef HDLC_RX_FCS_CHECK_EN
        bytes_q    <= '0;
`endif
      end else if (abort_b_q) begin
        state_q    <= IDLE;
        skip_q     <= '0;
        ones_q     <= '0;
        bitcnt_q   <= '0;
        had_data_q <= 1'b0;
`ifdef HDLC_RX_FCS_CHECK_EN
        bytes_q    <= '0;
`endif
      end else if (state_q == FRAME) begin
        // Remaining flag bits drain out of the window before data starts.
        if (skip_q != 3'd0) begin
          skip_q <= skip_q - 3'd1;
        end else if (!data_bit_d) begin
          ones_q <= '0;
        end else begin
          asm_q      <= asm_d;
          bitcnt_q   <= bitcnt_q + 3'd1;
          had_data_q <= 1'b1;
          if (bit_b_q)
            ones_q <= (ones_q == 3'd5) ? ones_q : ones_q + 3'd1;
          else
            ones_q <= '0;
          if (bitcnt_q == 3'd7) begin
            data_q <= asm_d;
            nb_q   <= 1'b1;
`ifdef HDLC_RX_FCS_CHECK_EN
            if (bytes_q != 2'd2)
              bytes_q <= bytes_q + 2'd1;
`endif
          end
        end
      end
    end
  end

  assign Rx_Data        = data_q;
  assign Rx_NewByte     = nb_q;
  assign Rx_FlagDetect  = flag_q;
  assign Rx_AbortDetect = abort_q;
  assign Rx_ValidFrame  = valid_q;
  assign Rx_EoF         = eof_q;
  assign Rx_FrameError  = ferr_q;

endmodule

// File: tb/tb_hdlc_rx_deframer.sv
// Directed bench for hdlc_rx_deframer; expectations adapt when HDLC_RX_FCS_CHECK_EN is defined.
module tb_hdlc_rx_deframer;

`ifdef HDLC_RX_FCS_CHECK_EN
  localparam logic FCS_EN = 1'b1;
`else
  localparam logic FCS_EN = 1'b0;
`endif

  logic       Clk = 1'b0;
  logic       Rst, Rx, RxEN;
  logic [7:0] Rx_Data;
  logic       Rx_NewByte, Rx_FlagDetect, Rx_AbortDetect, Rx_ValidFrame;
  logic       Rx_EoF, Rx_FrameError, Rx_FCSerr;

  hdlc_rx_deframer dut (
    .Clk            (Clk),
    .Rst            (Rst),
    .Rx             (Rx),
    .RxEN           (RxEN),
    .Rx_Data        (Rx_Data),
    .Rx_NewByte     (Rx_NewByte),
    .Rx_FlagDetect  (Rx_FlagDetect),
    .Rx_AbortDetect (Rx_AbortDetect),
    .Rx_ValidFrame  (Rx_ValidFrame),
    .Rx_EoF         (Rx_EoF),
    .Rx_FrameError  (Rx_FrameError),
    .Rx_FCSerr      (Rx_FCSerr)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  // Event log, written only by this monitor.
  int         flag_cnt = 0, abort_cnt = 0, nb_cnt = 0, eof_cnt = 0, eof_orphan = 0;
  int         last_flag_cyc = -1, last_abort_cyc = -1, last_nb_cyc = -1, last_eof_cyc = -1;
  int         vf_rise_cyc = -1, vf_fall_cyc = -1;
  logic [7:0] last_data = 8'h00;
  logic       last_ferr = 1'b0, last_fcserr = 1'b0, vf_prev = 1'b0;

  always @(negedge Clk) begin
    if (Rx_FlagDetect === 1'b1) begin flag_cnt++; last_flag_cyc = cyc; end
    if (Rx_AbortDetect === 1'b1) begin abort_cnt++; last_abort_cyc = cyc; end
    if (Rx_NewByte === 1'b1) begin nb_cnt++; last_nb_cyc = cyc; last_data = Rx_Data; end
    if (Rx_EoF === 1'b1) begin
      eof_cnt++; last_eof_cyc = cyc; last_ferr = Rx_FrameError; last_fcserr = Rx_FCSerr;
      if (Rx_FlagDetect !== 1'b1) eof_orphan++;
    end
    if (Rx_ValidFrame === 1'b1 && !vf_prev) vf_rise_cyc = cyc;
    if (Rx_ValidFrame === 1'b0 && vf_prev) vf_fall_cyc = cyc;
    vf_prev = (Rx_ValidFrame === 1'b1);
  end

  int   tests = 0, fails = 0;
  int   last_t = 0;
  // Line model: cycle in which a 0 has been followed by the 7th consecutive 1.
  int   run_ones = 0, seven_cyc = -1;
  logic have_zero = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    Rx = b;
    @(posedge Clk);
    #1;
    last_t = cyc;
    if (!b) begin
      have_zero = 1'b1;
      run_ones  = 0;
    end else begin
      run_ones++;
      if (have_zero && run_ones == 7) seven_cyc = cyc;
    end
  endtask

  // Sends n bits of v, bit 0 first.
  task automatic send_bits(input logic [15:0] v, input int n);
    for (int i = 0; i < n; i++) send_bit(v[i]);
  endtask

  int t1, t2, t3, t4, t5, t7, ta, tb;
  int fc0, fca, nb0, nbb, nbc, e0, ec, ab0;

  initial begin
    Rst = 1'b0; RxEN = 1'b0; Rx = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
    chk("reset_outputs", {Rx_Data, Rx_NewByte, Rx_FlagDetect, Rx_AbortDetect,
                          Rx_ValidFrame, Rx_EoF, Rx_FrameError, Rx_FCSerr}, 32'h0);
    Rst = 1'b1; RxEN = 1'b1;

    // Idle ones straight after enable: no abort from the cleared window.
    send_bits(16'hFFFF, 12);
    chk("idle_no_abort", abort_cnt, 0);
    chk("idle_no_flag", flag_cnt, 0);

    // Opening flag, then 0xA5, then closing flag.
    fc0 = flag_cnt;
    send_bits(16'h007E, 8);  t1 = last_t;
    send_bits(16'h00A5, 8);
    chk("open_flag_lat", last_flag_cyc, t1 + 2);
    chk("open_flag_cnt", flag_cnt - fc0, 1);
    chk("valid_rise_lat", vf_rise_cyc, t1 + 3);
    nb0 = nb_cnt; e0 = eof_cnt;
    send_bits(16'h007E, 8);  t2 = last_t;
    send_bits(16'h003F, 7);  t3 = last_t;  // idle fill flag sharing the 0
    chk("a5_newbyte_cnt", nb_cnt - nb0, 1);
    chk("a5_data", last_data, 8'hA5);
    chk("a5_newbyte_early", (last_nb_cyc <= t2 + 1), 1);
    chk("a5_eof_lat", last_eof_cyc, t2 + 2);
    chk("a5_eof_cnt", eof_cnt - e0, 1);
    chk("a5_frame_err", last_ferr, FCS_EN);

    // 0x7E sent with a stuffed zero; fill flag opens the frame.
    fca = flag_cnt; nbb = nb_cnt;
    send_bits(16'h00BE, 9);
    chk("fill_no_eof", eof_cnt - e0, 1);
    chk("fill_flag_lat", last_flag_cyc, t3 + 2);
    send_bits(16'h007E, 8);  t4 = last_t;
    send_bits(16'h034D, 11); // 11 data bits
    chk("x7e_flag_cnt", flag_cnt - fca, 2);
    chk("x7e_newbyte_cnt", nb_cnt - nbb, 1);
    chk("x7e_data", last_data, 8'h7E);
    chk("x7e_eof_lat", last_eof_cyc, t4 + 2);

    // 11-bit frame closes misaligned; then 0xFF stuffed and an abort.
    nbc = nb_cnt; ec = eof_cnt; ab0 = abort_cnt;
    send_bits(16'h007E, 8);  t5 = last_t;
    send_bits(16'h01DF, 9);
    send_bits(16'h01FF, 9);
    chk("odd_newbyte_cnt", nb_cnt - nbc, 1);
    chk("odd_data", last_data, 8'h4D);
    chk("odd_eof_lat", last_eof_cyc, t5 + 2);
    chk("odd_frame_err", last_ferr, 1'b1);
    chk("abort_no_eof", eof_cnt - ec, 1);
    chk("abort_lat", last_abort_cyc, seven_cyc + 2);
    chk("abort_cnt", abort_cnt - ab0, 1);
    chk("valid_fall_lat", vf_fall_cyc, seven_cyc + 3);

    // Reset in the middle of a frame.
    send_bits(16'h007E, 8);  t7 = last_t;
    send_bits(16'h0015, 5);
    chk("midframe_valid", Rx_ValidFrame, 1'b1);
    Rst = 1'b0;
    @(posedge Clk);
    #1;
    chk("midframe_reset", {Rx_Data, Rx_NewByte, Rx_FlagDetect, Rx_AbortDetect,
                           Rx_ValidFrame, Rx_EoF, Rx_FrameError, Rx_FCSerr}, 32'h0);
    Rst = 1'b1;
    have_zero = 1'b0; run_ones = 0;

    // Frame 0x01 + FCS 0x89,0x11 (CRC 0x9188), then the same with one FCS bit flipped.
    send_bits(16'hFFFF, 10);
    send_bits(16'h007E, 8);
    send_bits(16'h0001, 8);
    send_bits(16'h0089, 8);
    send_bits(16'h0011, 8);
    send_bits(16'h007E, 8);  ta = last_t;
    send_bits(16'h0001, 8);
    chk("fcs_ok_eof_lat", last_eof_cyc, ta + 2);
    chk("fcs_ok_data", last_data, 8'h11);
    chk("fcs_ok_frame_err", last_ferr, 1'b0);
    chk("fcs_ok_fcserr", last_fcserr, 1'b0);
    send_bits(16'h0089, 8);
    send_bits(16'h0010, 8);
    send_bits(16'h007E, 8);  tb = last_t;
    send_bits(16'h0007, 3);
    chk("fcs_bad_eof_lat", last_eof_cyc, tb + 2);
    chk("fcs_bad_data", last_data, 8'h10);
    chk("fcs_bad_frame_err", last_ferr, 1'b0);
    chk("fcs_bad_fcserr", last_fcserr, FCS_EN);
    chk("eof_with_flag", eof_orphan, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/hdlc_rx_deframer.md
# hdlc_rx_deframer

Bit-level front end of the HDLC receive path. It samples the serial `Rx` line, detects flags and aborts, removes stuffed zeros, and assembles data bytes, which it delivers LSB-first with frame delimiters to the Rx buffer/control stage. Its `Rx_FlagDetect`, `Rx_AbortDetect` and `Rx_ValidFrame` outputs drive the downstream abort and status logic and are covered by the Rx concurrent assertions.

## Interface
- `FLAG`, 8'h7E, flag pattern, oldest bit = bit 0.
- `ABORT_ONES`, 7, count of consecutive 1s that constitutes an abort.
- `Clk` in 1: single clock, all logic on posedge.
- `Rst` in 1: reset, synchronous, active-low.
- `Rx` in 1: serial receive bit, one bit per cycle.
- `RxEN` in 1: receiver enable.
- `Rx_Data` out 8: assembled byte, LSB = first received bit.
- `Rx_NewByte` out 1: one-cycle strobe, `Rx_Data` valid.
- `Rx_FlagDetect` out 1: one-cycle pulse per flag.
- `Rx_AbortDetect` out 1: one-cycle pulse per abort.
- `Rx_ValidFrame` out 1: high while inside a frame.
- `Rx_EoF` out 1: one-cycle end-of-frame pulse.
- `Rx_FrameError` out 1: one-cycle pulse with `Rx_EoF`, non-byte-aligned frame.
- `Rx_FCSerr` out 1: one-cycle pulse with `Rx_EoF`, FCS mismatch (0 when FCS check compiled out).

## Operation
- Reset (`Rst`=0 at posedge): every output 0, shift register cleared to all 0s, counters 0, state IDLE.
- `RxEN`=0: same as reset, applied each cycle; detection requires 8 fresh samples after `RxEN` rises.
- States: IDLE (outside a frame) and FRAME (`Rx_ValidFrame`=1).
- Flag: the 8 most recent samples equal 0,1,1,1,1,1,1,0. Flags may share one 0 bit (0111111011111 10…).
- IDLE -> FRAME on a flag. FRAME -> FRAME on a flag (shared closing/opening flag). FRAME -> IDLE on an abort.
- Abort: a 0 followed by `ABORT_ONES` 1s. Continued 1s do not produce further pulses. Pulses in either state.
- Zero removal inside FRAME: a 0 following five consecutive data 1s is discarded and does not count as a data bit.
- Flag bits are never emitted as data. The first data bit is the first sample after the opening flag's final 0.
- Data bits shift into `Rx_Data` LSB-first. Every 8th data bit produces `Rx_NewByte`. The bit counter is 3 bits and wraps.
- Flag in FRAME with at least one data bit since the previous flag -> `Rx_EoF`.
  - `Rx_FrameError`=1 if the bit counter != 0. The partial byte is dropped.
- Flag in FRAME with zero data bits (idle flag fill) -> no `Rx_EoF`.
- Abort in FRAME: no `Rx_EoF`. The partial byte is dropped and counters are cleared.

## Timing
- Let t = the cycle the final bit of a pattern is sampled.
- `Rx_FlagDetect` at t+2.
- `Rx_AbortDetect` at t+2, where t is the cycle the 7th consecutive 1 is sampled.
- `Rx_ValidFrame` rises at t+3 after an opening flag.
- On abort, `Rx_ValidFrame` is still 1 in the `Rx_AbortDetect` cycle and falls at t+3.
- `Rx_NewByte` for the last full byte of a frame arrives no later than `Rx_FlagDetect` − 1 of the closing flag.
- `Rx_EoF`, `Rx_FrameError` and `Rx_FCSerr` are coincident with the closing `Rx_FlagDetect`.
- `Rx_Data` is stable from `Rx_NewByte` until the next `Rx_NewByte`.
- Flag and abort are mutually exclusive by pattern. A stuffed zero is never the start of a flag.

## Configuration
- `HDLC_RX_FCS_CHECK_EN` defined:
  - CRC-16-CCITT (poly 0x1021, init 0x0000, data LSB-first) runs over all unstuffed data bits, including the 2 trailing FCS bytes.
  - `Rx_FCSerr`=1 at `Rx_EoF` if the residue != 0.
  - A byte-aligned frame shorter than 2 bytes raises `Rx_FrameError`.
  - CRC resets on every flag and abort.
- Undefined: no CRC logic, `Rx_FCSerr` tied 0, no minimum length.

## Structure
- Shared package `hdlc_pkg`:
  - flag constant.
  - abort length.
  - CRC polynomial and residue.
  - `rx_state_t` enum {IDLE, FRAME}.
- Sub-module `hdlc_crc16`: serial CRC update with enable and clear. Instantiated only under the macro.

## Test plan
- Flag 01111110 into IDLE -> `Rx_FlagDetect`=1 exactly 2 cycles after the last 0, `Rx_ValidFrame`=1 one cycle later.
- Flag, byte 0xA5 (bits 1,0,1,0,0,1,0,1), flag -> one `Rx_NewByte` with `Rx_Data`=0xA5, then `Rx_EoF`=1 and `Rx_FrameError`=0 with the closing `Rx_FlagDetect`.
- Flag, data 0x7E sent stuffed as 0,1,1,1,1,1,0,1,0, flag -> `Rx_Data`=0x7E, only 2 `Rx_FlagDetect` pulses.
- Flag, 0xFF (stuffed), then 1111111 -> `Rx_AbortDetect` 2 cycles after the 7th 1, `Rx_ValidFrame` falls 1 cycle later, no `Rx_EoF`.
- Flag, 11 data bits, flag -> one `Rx_NewByte`, `Rx_EoF` with `Rx_FrameError`=1.
- With `HDLC_RX_FCS_CHECK_EN`: frame 0x01 plus correct FCS -> `Rx_FCSerr`=0; flip one FCS bit -> `Rx_FCSerr`=1. `Rst`=0 mid-frame -> all outputs 0 next cycle.
